tdm_demux: RTL and testbench

Time-division demultiplexer that splits one serial sample stream into N_CH parallel output channels, one sample per slot. It is the receive-side counterpart of the team's mux blocks. An upstream mux/serialiser sends a slot-0 frame marker, and this block locks onto it, steers each sample to its channel register and flags framing errors. It sits between a shared data path and the per-channel consumers.

---
 rtl/tdm_pkg.sv | 15 +
 rtl/tdm_slot_counter.sv | 35 +++
 rtl/tdm_demux.sv | 117 +++++++++++
 tb/tb_tdm_demux.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Shared TDM definitions: frame-lock FSM encoding and slot-width helper.
// Used by the demux here and by the matching mux/serialiser.
package tdm_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } tdm_state_e;

    // Slot counter width for n slots; at least one bit so a 2-slot frame still counts.
    function automatic int unsigned slot_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Frame slot counter: loads 1 on a frame start, advances per beat and wraps after N_CH-1.
// last is registered alongside slot so the final slot is known without a decode.
module tdm_slot_counter
    import tdm_pkg::*;
#(
    parameter int unsigned N_CH   = 4,
    parameter int unsigned SLOT_W = slot_width(N_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clear_to_one,
    output logic [SLOT_W-1:0] slot,
    output logic              last
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot <= '0;
            last <= 1'b0;
        end else if (clear_to_one) begin
            slot <= SLOT_W'(1);
            last <= (N_CH == 2);
        end else if (en) begin
            if (last) begin
                slot <= '0;
                last <= 1'b0;
            end else begin
                slot <= slot + SLOT_W'(1);
                last <= (slot == SLOT_W'(N_CH - 2));
            end
        end
    end

endmodule

// File: rtl/tdm_demux.sv
// Time-division demultiplexer: locks onto the slot-0 marker and steers each
// serial sample into its channel register, flagging framing violations.
module tdm_demux
    import tdm_pkg::*;
#(
    parameter int unsigned N_CH   = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        din,
    input  logic                     din_valid,
    input  logic                     frame_sync,
    output logic [N_CH*DATA_W-1:0]   dout,
    output logic [N_CH-1:0]          dout_valid,
    output logic                     frame_done,
    output logic                     locked,
    output logic                     sync_err
);

    localparam int unsigned SLOT_W = slot_width(N_CH);

    tdm_state_e        state;
    tdm_state_e        state_n;
    logic [SLOT_W-1:0] slot;
    logic              last;
    logic              cnt_en;
    logic              cnt_load;
    logic              wr_en;
    logic [SLOT_W-1:0] wr_slot;
    logic [N_CH-1:0]   valid_n;
    logic              frame_done_n;
    logic              sync_err_n;

    tdm_slot_counter #(
        .N_CH   (N_CH),
        .SLOT_W (SLOT_W)
    ) u_slot_counter (
        .clk          (clk),
        .rst          (rst),
        .en           (cnt_en),
        .clear_to_one (cnt_load),
        .slot         (slot),
        .last         (last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= HUNT;
        end else begin
            state <= state_n;
        end
    end

    // Next state, counter control and steering; idle cycles leave everything untouched.
    always_comb begin
        state_n      = state;
        cnt_en       = 1'b0;
        cnt_load     = 1'b0;
        wr_en        = 1'b0;
        wr_slot      = '0;
        frame_done_n = 1'b0;
        sync_err_n   = 1'b0;
        valid_n      = '0;
        if (din_valid) begin
            case (state)
                HUNT: begin
                    if (frame_sync) begin
                        wr_en    = 1'b1;
                        cnt_load = 1'b1;
                        state_n  = LOCKED;
                    end
                end
                LOCKED: begin
                    if (frame_sync) begin
                        // An early marker truncates the frame and restarts at slot 0.
                        wr_en      = 1'b1;
                        cnt_load   = 1'b1;
                        sync_err_n = (slot != '0);
                    end else if (slot != '0) begin
                        wr_en        = 1'b1;
                        wr_slot      = slot;
                        cnt_en       = 1'b1;
                        frame_done_n = last;
                    end else begin
                        sync_err_n = 1'b1;
                        state_n    = HUNT;
                    end
                end
            endcase
        end
        if (wr_en) begin
            valid_n[wr_slot] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout       <= '0;
            dout_valid <= '0;
            frame_done <= 1'b0;
            locked     <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            dout_valid <= valid_n;
            frame_done <= frame_done_n;
            locked     <= (state_n == LOCKED);
            sync_err   <= sync_err_n;
            for (int k = 0; k < int'(N_CH); k++) begin
                if (valid_n[k]) begin
                    dout[k*DATA_W +: DATA_W] <= din;
                end
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux.sv
// Bench for tdm_demux (N_CH=4, DATA_W=8): vector table through a scoreboard
// queue, plus a hand-written asynchronous reset check.
module tb_tdm_demux;

    localparam int unsigned N_CH   = 4;
    localparam int unsigned DATA_W = 8;

    logic                   clk        = 1'b0;
    logic                   rst        = 1'b1;
    logic [DATA_W-1:0]      din        = '0;
    logic                   din_valid  = 1'b0;
    logic                   frame_sync = 1'b0;
    logic [N_CH*DATA_W-1:0] dout;
    logic [N_CH-1:0]        dout_valid;
    logic                   frame_done;
    logic                   locked;
    logic                   sync_err;

    tdm_demux #(
        .N_CH   (N_CH),
        .DATA_W (DATA_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .frame_sync (frame_sync),
        .dout       (dout),
        .dout_valid (dout_valid),
        .frame_done (frame_done),
        .locked     (locked),
        .sync_err   (sync_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  valid;
        logic        fd;
        logic        se;
        logic        lk;
        logic [31:0] dout;
    } exp_t;

    typedef struct packed {
        logic       rst;
        logic       dv;
        logic       fs;
        logic [7:0] din;
        exp_t       exp;
    } vec_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic add(input logic r, input logic dv, input logic fs, input logic [7:0] d,
                       input logic [3:0] v, input logic fd, input logic se, input logic lk,
                       input logic [31:0] dq);
        vec_t t;
        t.rst = r; t.dv = dv; t.fs = fs; t.din = d;
        t.exp.valid = v; t.exp.fd = fd; t.exp.se = se; t.exp.lk = lk; t.exp.dout = dq;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input exp_t e);
        exp_t act;
        act = {dout_valid, frame_done, sync_err, locked, dout};
        n_vec++;
        if (act !== e) begin
            n_bad++;
            $display("FAIL %s: got valid=%b fd=%b se=%b lk=%b dout=%h, want valid=%b fd=%b se=%b lk=%b dout=%h",
                     name, act.valid, act.fd, act.se, act.lk, act.dout,
                     e.valid, e.fd, e.se, e.lk, e.dout);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        exp_t e;
        @(negedge clk);
        rst        = v.rst;
        din_valid  = v.dv;
        frame_sync = v.fs;
        din        = v.din;
        sb.push_back(v.exp);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL vec%0d: scoreboard empty", idx);
        end else begin
            e = sb.pop_front();
            check($sformatf("vec%0d", idx), e);
        end
    endtask

    initial begin
        // rst dv fs din   | valid fd se lk dout
        add(1, 0, 0, 8'h00, 4'b0000, 0, 0, 0, 32'h00000000);
        // lock and one frame
        add(0, 1, 1, 8'hA0, 4'b0001, 0, 0, 1, 32'h000000A0);
        add(0, 1, 0, 8'hA1, 4'b0010, 0, 0, 1, 32'h0000A1A0);
        add(0, 1, 0, 8'hA2, 4'b0100, 0, 0, 1, 32'h00A2A1A0);
        add(0, 1, 0, 8'hA3, 4'b1000, 1, 0, 1, 32'hA3A2A1A0);
        // missing sync at slot 0
        add(0, 1, 0, 8'h99, 4'b0000, 0, 1, 0, 32'hA3A2A1A0);
        // hunt discard, then relock
        add(0, 1, 0, 8'h11, 4'b0000, 0, 0, 0, 32'hA3A2A1A0);
        add(0, 1, 0, 8'h22, 4'b0000, 0, 0, 0, 32'hA3A2A1A0);
        add(0, 1, 1, 8'h33, 4'b0001, 0, 0, 1, 32'hA3A2A133);
        add(0, 0, 1, 8'hFF, 4'b0000, 0, 0, 1, 32'hA3A2A133);
        add(0, 1, 0, 8'h44, 4'b0010, 0, 0, 1, 32'hA3A24433);
        add(0, 1, 0, 8'h55, 4'b0100, 0, 0, 1, 32'hA3554433);
        add(0, 1, 0, 8'h66, 4'b1000, 1, 0, 1, 32'h66554433);
        // gaps in din_valid
        add(0, 1, 1, 8'h10, 4'b0001, 0, 0, 1, 32'h66554410);
        add(0, 0, 0, 8'hEE, 4'b0000, 0, 0, 1, 32'h66554410);
        add(0, 1, 0, 8'h20, 4'b0010, 0, 0, 1, 32'h66552010);
        add(0, 0, 0, 8'hEE, 4'b0000, 0, 0, 1, 32'h66552010);
        add(0, 0, 1, 8'hEE, 4'b0000, 0, 0, 1, 32'h66552010);
        add(0, 1, 0, 8'h30, 4'b0100, 0, 0, 1, 32'h66302010);
        add(0, 0, 0, 8'hEE, 4'b0000, 0, 0, 1, 32'h66302010);
        add(0, 1, 0, 8'h40, 4'b1000, 1, 0, 1, 32'h40302010);
        // early sync
        add(0, 1, 1, 8'h10, 4'b0001, 0, 0, 1, 32'h40302010);
        add(0, 1, 0, 8'h20, 4'b0010, 0, 0, 1, 32'h40302010);
        add(0, 1, 1, 8'h50, 4'b0001, 0, 1, 1, 32'h40302050);
        add(0, 1, 0, 8'h60, 4'b0010, 0, 0, 1, 32'h40306050);
        add(0, 1, 0, 8'h70, 4'b0100, 0, 0, 1, 32'h40706050);
        add(0, 1, 0, 8'h80, 4'b1000, 1, 0, 1, 32'h80706050);
        // reset mid-frame
        add(0, 1, 1, 8'hC0, 4'b0001, 0, 0, 1, 32'h807060C0);
        add(0, 1, 0, 8'hC1, 4'b0010, 0, 0, 1, 32'h8070C1C0);
        add(1, 0, 0, 8'h00, 4'b0000, 0, 0, 0, 32'h00000000);
        add(1, 1, 1, 8'hC2, 4'b0000, 0, 0, 0, 32'h00000000);
        add(0, 1, 0, 8'hD1, 4'b0000, 0, 0, 0, 32'h00000000);
        add(0, 1, 1, 8'hD0, 4'b0001, 0, 0, 1, 32'h000000D0);
        add(0, 1, 0, 8'hD1, 4'b0010, 0, 0, 1, 32'h0000D1D0);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], i);
        end

        // Reset must clear outputs immediately, without waiting for a clock edge.
        begin
            exp_t e;
            @(negedge clk);
            rst        = 1'b1;
            din_valid  = 1'b0;
            frame_sync = 1'b0;
            #1;
            e = '0;
            check("async_rst", e);
            @(negedge clk);
            rst = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
